alu_4bit: RTL and testbench

- 4-bit registered ALU with four operations selected by a 2-bit opcode: add with carry-in, subtract, bitwise AND, bitwise XOR.
- Built as four ripple-connected 1-bit ALU slices feeding an output register.
- It is the arithmetic core of the small datapath. Operands come from the register file, and the result/carry are captured one cycle later.

---
 rtl/alu_4bit_if.sv | 11 +
 rtl/alu_4bit.sv | 52 +++++
 tb/tb_alu_4bit.sv | 75 +++++++
 3 files changed

// File: rtl/alu_4bit_if.sv
// alu_4bit_if: operand/opcode inputs and registered result/carry outputs of the 4-bit ALU
interface alu_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [1:0] s_op;
  logic [3:0] z;
  logic       cout;
  modport master (output a, b, cin, s_op, input z, cout);
  modport slave (input a, b, cin, s_op, output z, cout);
endinterface

// File: rtl/alu_4bit.sv
// alu_4bit: four ripple-connected 1-bit ALU slices (add/sub/and/xor) feeding a result register
module alu_slice (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [1:0] s_op_i,
  output logic       z_o,
  output logic       c_o
);
  logic bb;
  logic p;
  always_comb begin
    bb = s_op_i[0] ? ~b_i : b_i;
    p = a_i ^ bb;
    c_o = (a_i & bb) | (c_i & p);
    z_o = s_op_i[1] ? (s_op_i[0] ? a_i ^ b_i : a_i & b_i) : p ^ c_i;
  end
endmodule

module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  alu_4bit_if.slave  bus
);
  logic [4:0] carry;
  logic [3:0] z_d, z_q;
  logic       cout_d, cout_q;
  assign carry[0] = bus.cin;
  for (genvar i = 0; i < 4; i++) begin : g_slice
    alu_slice u_slice (
      .a_i   (bus.a[i]),
      .b_i   (bus.b[i]),
      .c_i   (carry[i]),
      .s_op_i(bus.s_op),
      .z_o   (z_d[i]),
      .c_o   (carry[i+1])
    );
  end
  // the ripple carry is meaningless for logic ops, so it never reaches cout there
  assign cout_d = bus.s_op[1] ? 1'b0 : carry[4];
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 4'b0000;
      cout_q <= 1'b0;
    end else begin
      z_q <= z_d;
      cout_q <= cout_d;
    end
  end
  assign bus.z = z_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed vectors with a scoreboard queue checked by an independent monitor
module tb_alu_4bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];
  alu_4bit_if bus();
  alu_4bit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic ci, input logic [3:0] ez, input logic ec);
    @(negedge clk);
    rst = r;
    bus.s_op = op;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    exp_q.push_back({ec, ez});
  endtask

  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.cout, bus.z} !== e) begin
          errors++;
          $display("FAIL result #%0d: got cout=%b z=%h, want cout=%b z=%h",
                   checks, bus.cout, bus.z, e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    bus.a = 4'h0;
    bus.b = 4'h0;
    bus.cin = 1'b0;
    bus.s_op = 2'b00;
    apply(1, 2'b00, 4'hF, 4'hF, 1, 4'h0, 0);
    apply(0, 2'b00, 4'hF, 4'hF, 1, 4'hF, 1);
    apply(0, 2'b00, 4'h2, 4'h2, 0, 4'h4, 0);
    apply(0, 2'b00, 4'hF, 4'h1, 0, 4'h0, 1);
    apply(0, 2'b00, 4'h5, 4'h6, 1, 4'hC, 0);
    apply(0, 2'b01, 4'h2, 4'h3, 1, 4'hF, 0);
    apply(0, 2'b01, 4'h6, 4'h2, 1, 4'h4, 1);
    apply(0, 2'b01, 4'h5, 4'h5, 1, 4'h0, 1);
    apply(0, 2'b01, 4'h5, 4'h3, 0, 4'h1, 1);
    apply(0, 2'b10, 4'h2, 4'h2, 1, 4'h2, 0);
    apply(0, 2'b10, 4'hC, 4'hA, 0, 4'h8, 0);
    apply(0, 2'b11, 4'h2, 4'h6, 1, 4'h4, 0);
    apply(0, 2'b11, 4'hF, 4'hF, 0, 4'h0, 0);
    apply(0, 2'b00, 4'h3, 4'h4, 1, 4'h8, 0);
    apply(0, 2'b01, 4'h9, 4'h4, 1, 4'h5, 1);
    apply(1, 2'b10, 4'hF, 4'hF, 1, 4'h0, 0);
    apply(0, 2'b11, 4'h9, 4'h3, 0, 4'hA, 0);
    apply(0, 2'b00, 4'h7, 4'h9, 0, 4'h0, 1);
    apply(0, 2'b01, 4'h1, 4'h2, 1, 4'hF, 0);
    apply(0, 2'b10, 4'h6, 4'hB, 1, 4'h2, 0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
